// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Pipeline hazard control: load-use / RAW stalls, taken-branch
//            flush, EX operand forwarding and HLT drain.
//            Optional macro PIPE_FWD_EN enables operand forwarding.
// Revision : 1.0
// ============================================================================
module pipe_ctrl #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_hlt,
    input  logic              ex_br_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic              hlt
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_DRAIN_MEM = 2'd1,
        S_DRAIN_WB  = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_ex_valid;
    logic              r_ex_regwrite;
    logic              r_ex_memread;
    logic              r_ex_hlt;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_mem_valid;
    logic              r_mem_regwrite;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_wb_valid;
    logic              r_wb_regwrite;
    logic [REG_AW-1:0] r_wb_rd;
`ifdef PIPE_FWD_EN
    logic              r_ex_rs_used;
    logic              r_ex_rt_used;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_mem_memread;
`endif

    logic w_ex_take;
    logic w_br;
    logic w_halting;
    logic w_hit_ex;
    logic w_lu;
    logic w_hazard;

    // True when a live ID instruction reads nonzero register a_rd.
    function automatic logic src_match(
        input logic              a_v,
        input logic              a_u1,
        input logic [REG_AW-1:0] a_s1,
        input logic              a_u2,
        input logic [REG_AW-1:0] a_s2,
        input logic [REG_AW-1:0] a_rd
    );
        return a_v && (a_rd != '0) &&
               ((a_u1 && (a_s1 == a_rd)) || (a_u2 && (a_s2 == a_rd)));
    endfunction

    assign w_hit_ex  = src_match(id_valid, id_rs_used, id_rs, id_rt_used, id_rt, r_ex_rd);
    assign w_lu      = r_ex_valid & r_ex_memread & w_hit_ex;
    assign w_br      = r_ex_valid & ex_br_taken;
    assign w_halting = (r_state != S_RUN) | (r_ex_valid & r_ex_hlt);

`ifdef PIPE_FWD_EN
    function automatic logic [1:0] fwd_sel(
        input logic              a_use,
        input logic [REG_AW-1:0] a_src,
        input logic              a_mem_ok,
        input logic [REG_AW-1:0] a_mem_rd,
        input logic              a_wb_ok,
        input logic [REG_AW-1:0] a_wb_rd
    );
        if (!a_use || (a_src == '0)) return 2'b00;
        if (a_mem_ok && (a_mem_rd == a_src)) return 2'b01;
        if (a_wb_ok && (a_wb_rd == a_src)) return 2'b10;
        return 2'b00;
    endfunction

    // A load result in MEM is never a forwarding source; the load-use stall covers it.
    logic w_mem_fwd_ok;
    logic w_wb_fwd_ok;
    assign w_mem_fwd_ok = r_mem_valid & r_mem_regwrite & ~r_mem_memread;
    assign w_wb_fwd_ok  = r_wb_valid & r_wb_regwrite;
    assign fwd_a    = fwd_sel(r_ex_valid & r_ex_rs_used, r_ex_rs, w_mem_fwd_ok, r_mem_rd,
                              w_wb_fwd_ok, r_wb_rd);
    assign fwd_b    = fwd_sel(r_ex_valid & r_ex_rt_used, r_ex_rt, w_mem_fwd_ok, r_mem_rd,
                              w_wb_fwd_ok, r_wb_rd);
    assign w_hazard = w_lu;
`else
    logic w_hit_mem;
    logic w_hit_wb;
    assign w_hit_mem = src_match(id_valid, id_rs_used, id_rs, id_rt_used, id_rt, r_mem_rd);
    assign w_hit_wb  = src_match(id_valid, id_rs_used, id_rs, id_rt_used, id_rt, r_wb_rd);
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
    // Without forwarding, any pending writer of an ID source holds ID until it retires.
    assign w_hazard  = w_lu
                     | (r_ex_valid  & r_ex_regwrite  & w_hit_ex)
                     | (r_mem_valid & r_mem_regwrite & w_hit_mem)
                     | (r_wb_valid  & r_wb_regwrite  & w_hit_wb);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_ex   = 1'b0;
        case (r_state)
            S_RUN:       if (r_ex_valid && r_ex_hlt) w_state_nxt = S_DRAIN_MEM;
            S_DRAIN_MEM: w_state_nxt = S_DRAIN_WB;
            S_DRAIN_WB:  w_state_nxt = S_DONE;
            default:     w_state_nxt = S_DONE;
        endcase
        // Once HLT is in EX nothing younger may enter the pipe.
        if (w_halting) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (w_br) begin
            flush_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end else if (w_hazard) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble_ex  = 1'b1;
        end
    end

    assign w_ex_take = ~bubble_ex & id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_ex_hlt       <= 1'b0;
            r_ex_rd        <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
        end else begin
            r_ex_valid     <= w_ex_take;
            r_ex_regwrite  <= w_ex_take & id_regwrite;
            r_ex_memread   <= w_ex_take & id_memread;
            r_ex_hlt       <= w_ex_take & id_hlt;
            r_ex_rd        <= w_ex_take ? id_rd : '0;
            r_mem_valid    <= r_ex_valid;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_rd       <= r_ex_rd;
            r_wb_valid     <= r_mem_valid;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_rd        <= r_mem_rd;
        end
    end

`ifdef PIPE_FWD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rs_used  <= 1'b0;
            r_ex_rt_used  <= 1'b0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_mem_memread <= 1'b0;
        end else begin
            r_ex_rs_used  <= w_ex_take & id_rs_used;
            r_ex_rt_used  <= w_ex_take & id_rt_used;
            r_ex_rs       <= w_ex_take ? id_rs : '0;
            r_ex_rt       <= w_ex_take ? id_rt : '0;
            r_mem_memread <= r_ex_memread;
        end
    end
`endif

    assign ex_valid    = r_ex_valid;
    assign mem_valid   = r_mem_valid;
    assign wb_valid    = r_wb_valid;
    assign wb_regwrite = r_wb_valid & r_wb_regwrite;
    assign hlt         = (r_state == S_DONE);

endmodule
`default_nettype wire
